usb_tx_arb: RTL and testbench

USB_TX_ARB -- requirements
Module: usb_tx_arb

---
 rtl/usb_tx_arb.sv | 132 +++++++++++++
 tb/tb_usb_tx_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arb.sv
// Two-channel round-robin arbiter that frames requester messages for the FT232H TX FIFO.
// Frame: SYNC_BYTE, channel byte, 1..MAX_LEN payload bytes, XOR checksum.
//
//   state | meaning
//   IDLE  | waiting for en and a valid requester
//   HDR   | writing SYNC_BYTE
//   CH    | writing channel byte {7'b0, grant}
//   PAY   | forwarding granted requester bytes
//   CSUM  | writing checksum, counting the frame
module usb_tx_arb #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 64
) (
    input  logic        usb_clk_60m,
    input  logic        rst_n,
    input  logic        en,
    input  logic        s0_valid,
    input  logic [7:0]  s0_data,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [7:0]  s1_data,
    input  logic        s1_last,
    output logic        s1_ready,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_din,
    output logic        busy,
    output logic        grant,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CH,
        ST_PAY,
        ST_CSUM
    } state_t;

    localparam logic [6:0] LAST_CNT = 7'(MAX_LEN - 1);

    state_t     state, state_nxt;
    logic       last_grant;
    logic [6:0] pay_cnt;
    logic [7:0] csum;
    logic       sel_valid, sel_last, grant_pick, take;
    logic [7:0] sel_data;

    assign sel_valid  = grant ? s1_valid : s0_valid;
    assign sel_data   = grant ? s1_data  : s0_data;
    assign sel_last   = grant ? s1_last  : s0_last;
    // On a tie the channel not served last wins; otherwise whichever is valid.
    assign grant_pick = (s0_valid && s1_valid) ? ~last_grant : s1_valid;
    assign take       = (state == ST_PAY) && sel_valid && !fifo_full;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt  = state;
        fifo_wr_en = 1'b0;
        fifo_din   = 8'h00;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && (s0_valid || s1_valid))
                    state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = SYNC_BYTE;
                    state_nxt  = ST_CH;
                end
            end
            ST_CH: begin
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = {7'b0, grant};
                    state_nxt  = ST_PAY;
                end
            end
            ST_PAY: begin
                s0_ready = !grant && !fifo_full;
                s1_ready = grant && !fifo_full;
                if (take) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = sel_data;
                    if (sel_last || pay_cnt == LAST_CNT)
                        state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = csum;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge usb_clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            pay_cnt    <= 7'd0;
            csum       <= 8'h00;
            pkt_cnt    <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_HDR) begin
                grant   <= grant_pick;
                pay_cnt <= 7'd0;
                csum    <= 8'h00;
            end
            if (state == ST_CH && fifo_wr_en)
                csum <= {7'b0, grant};
            if (take) begin
                pay_cnt <= pay_cnt + 7'd1;
                csum    <= csum ^ sel_data;
            end
            if (state == ST_CSUM && fifo_wr_en) begin
                pkt_cnt    <= pkt_cnt + 16'd1;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_arb.sv
// Self-checking bench for usb_tx_arb: queued requester drivers, FIFO capture, and a
// frame-level model that rebuilds the expected byte stream from the queued messages.
module tb_usb_tx_arb;

    localparam int MAX_LEN = 64;

    logic        usb_clk_60m = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        s0_valid = 1'b0, s0_last = 1'b0, s0_ready;
    logic        s1_valid = 1'b0, s1_last = 1'b0, s1_ready;
    logic [7:0]  s0_data = 8'h00, s1_data = 8'h00;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en, busy, grant;
    logic [7:0]  fifo_din;
    logic [15:0] pkt_cnt;

    usb_tx_arb #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN)) dut (
        .usb_clk_60m(usb_clk_60m), .rst_n(rst_n), .en(en),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .busy(busy), .grant(grant), .pkt_cnt(pkt_cnt)
    );

    always #8 usb_clk_60m = ~usb_clk_60m;

    int errors = 0, checks = 0, cyc = 0, viol = 0;
    logic [8:0] q0[$], q1[$], m0[$], m1[$];
    logic [7:0] got[$], exp_q[$];
    int         got_cyc[$];
    bit         rand_full = 0, force_full = 0;
    int         model_lg = 1;
    int         model_pkt = 0;

    // Drive on the falling edge, sample just before the rising edge.
    initial begin
        forever begin
            @(negedge usb_clk_60m);
            s0_valid = (q0.size() != 0);
            {s0_last, s0_data} = (q0.size() != 0) ? q0[0] : 9'h0;
            s1_valid = (q1.size() != 0);
            {s1_last, s1_data} = (q1.size() != 0) ? q1[0] : 9'h0;
            fifo_full = force_full | (rand_full && ($urandom_range(0, 3) == 0));
            #6;
            cyc++;
            if ($isunknown({fifo_wr_en, fifo_din, s0_ready, s1_ready, busy})) viol++;
            if (fifo_wr_en === 1'b0 && fifo_din !== 8'h00) viol++;
            if (fifo_full && (fifo_wr_en || s0_ready || s1_ready)) viol++;
            if (s0_ready === 1'b1 && grant !== 1'b0) viol++;
            if (s1_ready === 1'b1 && grant !== 1'b1) viol++;
            if (fifo_wr_en === 1'b1) begin
                got.push_back(fifo_din);
                got_cyc.push_back(cyc);
            end
            if (s0_valid && s0_ready === 1'b1 && q0.size() != 0) void'(q0.pop_front());
            if (s1_valid && s1_ready === 1'b1 && q1.size() != 0) void'(q1.pop_front());
        end
    end

    task automatic push_byte(input int ch, input logic [7:0] d, input bit last);
        if (ch == 0) begin q0.push_back({last, d}); m0.push_back({last, d}); end
        else         begin q1.push_back({last, d}); m1.push_back({last, d}); end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge usb_clk_60m);
        #1;
    endtask

    task automatic clear_streams();
        got.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    // Frame-level model: assumes every queued message is presented continuously.
    task automatic model_run();
        int ch, n;
        logic [7:0] x;
        logic [8:0] b;
        while (m0.size() != 0 || m1.size() != 0) begin
            if (m0.size() != 0 && m1.size() != 0) ch = 1 - model_lg;
            else ch = (m0.size() != 0) ? 0 : 1;
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(ch));
            x = 8'(ch);
            n = 0;
            do begin
                b = (ch == 0) ? m0.pop_front() : m1.pop_front();
                exp_q.push_back(b[7:0]);
                x ^= b[7:0];
                n++;
            end while (!b[8] && n < MAX_LEN);
            exp_q.push_back(x);
            model_lg = ch;
            model_pkt++;
        end
    endtask

    task automatic wait_stream(input int limit);
        for (int i = 0; i < limit && got.size() < exp_q.size(); i++) tick(1);
        tick(4);
    endtask

    task automatic test_reset();
        push_byte(0, 8'h5A, 1);
        push_byte(1, 8'hC3, 1);
        en = 1'b1;
        tick(3);
        checks++;
        if ({fifo_wr_en, fifo_din, s0_ready, s1_ready, busy, grant} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b din=%02h rdy=%b%b busy=%b grant=%b, expected all 0",
                     fifo_wr_en, fifo_din, s0_ready, s1_ready, busy, grant);
        end
        checks++;
        if (pkt_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt);
        end
        checks++;
        if (got.size() !== 0) begin
            errors++; $display("FAIL reset_no_write: got %0d writes expected 0", got.size());
        end
    endtask

    task automatic test_tie();
        clear_streams();
        model_run();
        rst_n = 1'b1;
        wait_stream(200);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL tie_len: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL tie_byte[%0d]: got %02h expected %02h", i, got[i], exp_q[i]);
            end
        end
        if (got_cyc.size() >= 5) begin
            checks++;
            if (got_cyc[4] - got_cyc[3] !== 2) begin
                errors++; $display("FAIL tie_idle_gap: got %0d cycles expected 2", got_cyc[4] - got_cyc[3]);
            end
        end
    endtask

    task automatic test_single();
        int c0;
        clear_streams();
        c0 = cyc;
        push_byte(0, 8'h11, 0);
        push_byte(0, 8'h22, 0);
        push_byte(0, 8'h33, 1);
        model_run();
        wait_stream(200);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL single_len: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_byte[%0d]: got %02h expected %02h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] !== c0 + 2) begin
            errors++; $display("FAIL single_latency: got cycle %0d expected %0d",
                               got_cyc.size() ? got_cyc[0] : -1, c0 + 2);
        end
        checks++;
        if (pkt_cnt !== 16'(model_pkt)) begin
            errors++; $display("FAIL single_pkt_cnt: got %0d expected %0d", pkt_cnt, model_pkt);
        end
    endtask

    task automatic test_split();
        clear_streams();
        for (int i = 1; i <= 70; i++) push_byte(1, 8'h01, i == 70);
        model_run();
        wait_stream(500);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL split_len: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL split_byte[%0d]: got %02h expected %02h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'(model_pkt)) begin
            errors++; $display("FAIL split_pkt_cnt: got %0d expected %0d", pkt_cnt, model_pkt);
        end
    endtask

    task automatic test_full_stall();
        int held;
        clear_streams();
        for (int i = 0; i < 10; i++) push_byte(0, 8'(8'h40 + i), i == 9);
        model_run();
        for (int i = 0; i < 100 && got.size() < 4; i++) tick(1);
        force_full = 1'b1;
        held = got.size();
        tick(1);
        repeat (5) begin
            tick(1);
            checks++;
            if (s0_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
                errors++; $display("FAIL full_hold: got ready=%b wr=%b expected 0 0", s0_ready, fifo_wr_en);
            end
        end
        checks++;
        if (got.size() !== held) begin
            errors++; $display("FAIL full_no_write: got %0d bytes expected %0d", got.size(), held);
        end
        force_full = 1'b0;
        wait_stream(200);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL full_len: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL full_byte[%0d]: got %02h expected %02h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_en_drop();
        clear_streams();
        push_byte(0, 8'hE1, 0);
        push_byte(0, 8'hE2, 1);
        model_run();
        for (int i = 0; i < 100 && got.size() < 1; i++) tick(1);
        en = 1'b0;
        push_byte(1, 8'h77, 1);
        tick(20);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL en_frame_done: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        checks++;
        if (busy !== 1'b0 || q1.size() !== 1) begin
            errors++; $display("FAIL en_blocked: got busy=%b pending=%0d expected busy=0 pending=1", busy, q1.size());
        end
        model_run();
        en = 1'b1;
        wait_stream(200);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL en_len: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL en_byte[%0d]: got %02h expected %02h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_streams();
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 6; k++) begin
                int len;
                len = $urandom_range(1, 80);
                for (int i = 1; i <= len; i++) push_byte(ch, 8'($urandom), i == len);
            end
        end
        model_run();
        rand_full = 1;
        wait_stream(6000);
        rand_full = 0;
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_len: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_byte[%0d]: got %02h expected %02h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'(model_pkt)) begin
            errors++; $display("FAIL rand_pkt_cnt: got %0d expected %0d", pkt_cnt, model_pkt);
        end
    endtask

    task automatic test_reset_mid();
        clear_streams();
        for (int i = 0; i < 8; i++) push_byte(1, 8'(8'h90 + i), i == 7);
        for (int i = 0; i < 100 && got.size() < 4; i++) tick(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_wr_en, fifo_din, s0_ready, s1_ready, busy, grant} !== 13'h0 || pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got wr=%b din=%02h rdy=%b%b busy=%b grant=%b pkt=%0d, expected all 0",
                     fifo_wr_en, fifo_din, s0_ready, s1_ready, busy, grant, pkt_cnt);
        end
        q1.delete(); m1.delete();
        clear_streams();
        model_lg = 1;
        model_pkt = 0;
        tick(3);
        checks++;
        if (got.size() !== 0) begin
            errors++; $display("FAIL midreset_no_write: got %0d writes expected 0", got.size());
        end
        push_byte(1, 8'h81, 1);
        push_byte(0, 8'h3C, 1);
        model_run();
        rst_n = 1'b1;
        wait_stream(200);
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL midreset_len: got %0d bytes expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL midreset_byte[%0d]: got %02h expected %02h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'(model_pkt)) begin
            errors++; $display("FAIL midreset_pkt_cnt: got %0d expected %0d", pkt_cnt, model_pkt);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL protocol: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_split();
        test_full_stall();
        test_en_drop();
        test_random();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
